// File: rtl/adder_tree_accum.sv
// adder_tree_accum: pipelined NCH-lane binary adder tree followed by a block
// accumulator that integrates ACC_LEN valid tree sums per output result.
//
// Build option: define ADDER_TREE_SIGNED_EN for two's complement lanes
// (sign extension, signed acc/odata); leave it undefined for unsigned lanes.
//
// Ports:
//   iCLK    clock, rising edge
//   iRSTn   asynchronous active-low reset
//   iEN     pipeline enable; low freezes all registers (ovalid drops to 0)
//   iCLR    synchronous flush of accumulator, counter and tree valid bits
//   iVALID  idata carries a sample this cycle
//   idata   NCH packed lanes, lane k at idata[k*WL +: WL]
//   ovalid  one-cycle result strobe
//   odata   accumulated result, held between strobes
module adder_tree_accum #(
   parameter int unsigned WL      = 8,
   parameter int unsigned NCH     = 4,
   parameter int unsigned ACC_LEN = 4
) (
   input  logic                                           iCLK,
   input  logic                                           iRSTn,
   input  logic                                           iEN,
   input  logic                                           iCLR,
   input  logic                                           iVALID,
   input  logic [NCH*WL-1:0]                              idata,
   output logic                                           ovalid,
`ifdef ADDER_TREE_SIGNED_EN
   output logic signed [WL+$clog2(NCH)+$clog2(ACC_LEN)-1:0] odata
`else
   output logic        [WL+$clog2(NCH)+$clog2(ACC_LEN)-1:0] odata
`endif
);

   localparam int unsigned LOG2NCH = $clog2(NCH);
   localparam int unsigned OWL     = WL + LOG2NCH + $clog2(ACC_LEN);
   localparam int unsigned CW      = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int unsigned NSRC    = 2*NCH - 2;

   // Tree nodes in heap order: node i sums src[2i] and src[2i+1], where
   // src holds the extended lanes followed by the non-root nodes. Stage 1
   // occupies nodes 0..NCH/2-1, the root is node NCH-2. Nodes are carried at
   // OWL width; bits above the stage width are constant and trim away.
   logic [OWL-1:0]     node_q [0:NCH-2];
   logic [OWL-1:0]     src_c  [0:NSRC-1];
   logic [LOG2NCH-1:0] vld_q;

`ifdef ADDER_TREE_SIGNED_EN
   logic signed [OWL-1:0] acc_q;
`else
   logic        [OWL-1:0] acc_q;
`endif
   logic [CW-1:0]  cnt_q;
   logic [OWL-1:0] tree_sum_c;
   logic           tree_vld_c;
   logic           last_c;

   // Lane extension and operand routing for the tree
   always_comb begin
      for (int k = 0; k < NSRC; k++) begin
         src_c[k] = '0;
      end
      for (int k = 0; k < int'(NCH); k++) begin
`ifdef ADDER_TREE_SIGNED_EN
         src_c[k] = OWL'($signed(idata[k*WL +: WL]));
`else
         src_c[k] = OWL'(idata[k*WL +: WL]);
`endif
      end
      for (int i = 0; i < int'(NCH) - 2; i++) begin
         src_c[int'(NCH) + i] = node_q[i];
      end
   end

   // Tree registers and the valid bit travelling with each stage
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         for (int i = 0; i < int'(NCH) - 1; i++) begin
            node_q[i] <= '0;
         end
         vld_q <= '0;
      end else if (iCLR) begin
         vld_q <= '0;
      end else if (iEN) begin
         for (int i = 0; i < int'(NCH) - 1; i++) begin
            node_q[i] <= src_c[2*i] + src_c[2*i+1];
         end
         vld_q[0] <= iVALID;
         for (int s = 1; s < int'(LOG2NCH); s++) begin
            vld_q[s] <= vld_q[s-1];
         end
      end
   end

   assign tree_sum_c = node_q[NCH-2];
   assign tree_vld_c = vld_q[LOG2NCH-1];
   assign last_c     = (cnt_q == CW'(ACC_LEN - 1));

   // Block accumulator; the group's final sum goes straight to odata
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         odata  <= '0;
         ovalid <= 1'b0;
      end else if (iCLR) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         ovalid <= 1'b0;
      end else if (iEN) begin
         ovalid <= 1'b0;
         if (tree_vld_c) begin
            if (last_c) begin
               odata  <= acc_q + tree_sum_c;
               ovalid <= 1'b1;
               acc_q  <= '0;
               cnt_q  <= '0;
            end else begin
               acc_q  <= acc_q + tree_sum_c;
               cnt_q  <= cnt_q + CW'(1);
            end
         end
      end else begin
         // Stalled: nothing advances, and a strobe is never repeated
         ovalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum: directed bench for adder_tree_accum with WL=8, NCH=4,
// ACC_LEN=4 (OWL=12). Inputs change on the falling edge; outputs are checked
// on the falling edge, so a check reflects the preceding rising edge.
module tb_adder_tree_accum;

   logic        iCLK;
   logic        iRSTn;
   logic        iEN;
   logic        iCLR;
   logic        iVALID;
   logic [31:0] idata;
   logic        ovalid;
   logic [11:0] odata;

   int n_cmp = 0;
   int n_bad = 0;
   int stepno = 0;

`ifdef ADDER_TREE_SIGNED_EN
   localparam logic [11:0] EXP_ONE_80 = 12'hF80;   // -128
`else
   localparam logic [11:0] EXP_ONE_80 = 12'h080;   // 128
`endif

   adder_tree_accum #(.WL(8), .NCH(4), .ACC_LEN(4)) dut (
      .iCLK   (iCLK),
      .iRSTn  (iRSTn),
      .iEN    (iEN),
      .iCLR   (iCLR),
      .iVALID (iVALID),
      .idata  (idata),
      .ovalid (ovalid),
      .odata  (odata)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   function automatic logic [31:0] lanes(input logic [7:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [31:0] all4(input logic [7:0] v);
      return {v, v, v, v};
   endfunction

   task automatic chk_ovalid(input string tag, input logic exp);
      n_cmp++;
      assert (ovalid === exp) else begin
         n_bad++;
         $error("FAIL %s step=%0d ovalid got=%b exp=%b", tag, stepno, ovalid, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [11:0] exp);
      n_cmp++;
      assert (odata === exp) else begin
         n_bad++;
         $error("FAIL %s step=%0d odata got=0x%03h exp=0x%03h", tag, stepno, odata, exp);
      end
   endtask

   // Check ovalid from the previous edge, then drive the next cycle's inputs
   task automatic step(input logic en, input logic clr, input logic v,
                       input logic [31:0] d, input logic exp_ov);
      @(negedge iCLK);
      chk_ovalid("ovalid", exp_ov);
      stepno++;
      iEN    = en;
      iCLR   = clr;
      iVALID = v;
      idata  = d;
   endtask

   // Four back-to-back samples; strobe expected three cycles after the last
   task automatic group4(input string tag, input logic [31:0] d0, d1, d2, d3,
                         input logic [11:0] exp);
      step(1'b1, 1'b0, 1'b1, d0, 1'b0);
      step(1'b1, 1'b0, 1'b1, d1, 1'b0);
      step(1'b1, 1'b0, 1'b1, d2, 1'b0);
      step(1'b1, 1'b0, 1'b1, d3, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      chk_data(tag, exp);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      iRSTn  = 1'b0;
      iEN    = 1'b0;
      iCLR   = 1'b0;
      iVALID = 1'b0;
      idata  = '0;

      // Reset state
      @(posedge iCLK);
      @(posedge iCLK);
      @(negedge iCLK);
      chk_ovalid("rst_ovalid", 1'b0);
      chk_data("rst_odata", 12'h000);
      iRSTn = 1'b1;

      // Unsigned full scale: 16 x 0xFF
      group4("full_scale", all4(8'hFF), all4(8'hFF), all4(8'hFF), all4(8'hFF), 12'hFF0);

      // 0x80 lanes: 2048 or -2048, same 12-bit pattern
      group4("lanes_80", all4(8'h80), all4(8'h80), all4(8'h80), all4(8'h80), 12'h800);
      // A single 0x80 lane separates sign from zero extension
      group4("one_80", lanes(8'h80, 8'h00, 8'h00, 8'h00), '0, '0, '0, EXP_ONE_80);

      // Stall and bubbles: four samples of {1,2,3,4} -> 40
      step(1'b1, 1'b0, 1'b1, lanes(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, all4(8'h55), 1'b0);
      step(1'b0, 1'b0, 1'b1, all4(8'h55), 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, lanes(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
      step(1'b1, 1'b0, 1'b1, lanes(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, lanes(8'd1, 8'd2, 8'd3, 8'd4), 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk_data("stall_sum", 12'd40);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk_data("stall_hold", 12'd40);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Clear mid-group: two samples of 10, clear with a 99 sample, then 4 x 1
      step(1'b1, 1'b0, 1'b1, all4(8'd10), 1'b0);
      step(1'b1, 1'b0, 1'b1, all4(8'd10), 1'b0);
      step(1'b1, 1'b1, 1'b1, all4(8'd99), 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk_data("clr_hold", 12'd40);
      group4("clr_sum", all4(8'd1), all4(8'd1), all4(8'd1), all4(8'd1), 12'd16);

      // Back-to-back groups: lanes n for n=1..8 -> 40 then 104
      for (int k = 1; k <= 12; k++) begin
         step(1'b1, 1'b0, k <= 8, (k <= 8) ? all4(8'(k)) : 32'h0, (k == 7) || (k == 11));
         if (k == 7)  chk_data("b2b_first", 12'd40);
         if (k == 9)  chk_data("b2b_hold", 12'd40);
         if (k == 11) chk_data("b2b_second", 12'd104);
      end

      // Reset mid-stream, then a clean group of all-1 lanes
      step(1'b1, 1'b0, 1'b1, all4(8'd7), 1'b0);
      step(1'b1, 1'b0, 1'b1, all4(8'd7), 1'b0);
      #2 iRSTn = 1'b0;
      #1;
      chk_ovalid("async_rst_ovalid", 1'b0);
      chk_data("async_rst_odata", 12'h000);
      @(negedge iCLK);
      iRSTn  = 1'b1;
      iVALID = 1'b0;
      idata  = '0;
      group4("post_rst", all4(8'd1), all4(8'd1), all4(8'd1), all4(8'd1), 12'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adder_tree_accum.md
# adder_tree_accum

Parametrised pipelined multi-channel adder with a block accumulator, the successor to the single-pair registered adder. It sums NCH parallel lanes through a registered binary adder tree, then integrates ACC_LEN consecutive valid tree sums and emits one result with a valid pulse. It sits in the radar STFT datapath ahead of magnitude and feature buffering, where it does bin/channel integration. Signed or unsigned arithmetic is selected at compile time.

## Interface
- WL, 8: lane data width in bits.
- NCH, 4: number of input lanes; power of 2, ≥ 2.
- ACC_LEN, 4: valid tree sums per output result; ≥ 1.
- Derived, not overridable: LOG2NCH = clog2(NCH), OWL = WL + LOG2NCH + clog2(ACC_LEN).

Ports:
- iCLK  in  1  clock; all state changes on its rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iEN  in  1  pipeline enable; low freezes every register except ovalid.
- iCLR  in  1  synchronous flush of accumulator, counter and tree valid bits.
- iVALID  in  1  idata holds a sample this cycle.
- idata  in  NCH*WL  packed lanes; lane k is idata[k*WL +: WL].
- ovalid  out  1  one-cycle result strobe.
- odata  out  OWL  accumulated result; holds between strobes.

## Operation
- Tree: LOG2NCH registered stages. Stage s holds NCH>>s partial sums, each one bit wider than the previous stage. A valid bit travels alongside each stage.
- Lanes are extended to OWL before addition, so no overflow is possible. Extension is zero or sign per Configuration.
- Accumulator: an OWL-bit register acc and a counter cnt (0..ACC_LEN-1). On each enabled edge where the tree output is valid:
  - If cnt < ACC_LEN-1: acc ← acc + tree, cnt ← cnt+1.
  - If cnt = ACC_LEN-1: odata ← acc + tree, ovalid ← 1, acc ← 0, cnt ← 0.
- ACC_LEN = 1: every valid tree sum is emitted directly.
- Invalid samples (iVALID = 0) enter the tree as bubbles. They never change acc or cnt.
- Gaps between samples of a group are allowed and do not affect the result.
- iCLR = 1 on any edge, regardless of iEN:
  - acc, cnt and all tree valid bits go to 0, and ovalid goes to 0.
  - A sample presented on the same edge is discarded.
  - odata holds.
- iEN = 0 and iCLR = 0: all data, valid and counter registers hold; ovalid ← 0. No strobe is ever repeated.
- Reset, asynchronous: all tree registers, valid bits, acc, cnt, odata and ovalid go to 0 immediately. A group in progress is lost, and no partial result is emitted.

## Timing
- Latency: a sample presented in cycle c reaches the tree output in cycle c+LOG2NCH. If it is the last sample of a group, ovalid = 1 and odata is valid in cycle c+LOG2NCH+1, counting enabled cycles only. Each disabled cycle adds one cycle.
- Throughput: one sample per enabled cycle, and one result per ACC_LEN valid samples.
- ovalid is high for exactly one cycle per result.
- odata changes only on the edge that raises ovalid, on reset, or never otherwise.
- Reset deassertion takes effect from the first rising edge after it. No sample is accepted while iRSTn = 0.

## Configuration
- ADDER_TREE_SIGNED_EN defined: lanes are two's complement and sign-extended; acc and odata are signed.
- Not defined: lanes are unsigned and zero-extended; acc and odata are unsigned.
- Register structure and latency are identical in both builds.

## Test plan
All cases use WL=8, NCH=4, ACC_LEN=4 (OWL=12), so the result strobe lands 3 cycles after the last sample.

- **Reset:** assert iRSTn=0 mid-stream → ovalid=0 and odata=0 immediately. After release, 4 samples of all-1 lanes → odata=16, with no residue from before reset.
- **Unsigned full scale** (macro undefined): 4 consecutive valid samples, all lanes 0xFF → a single ovalid pulse 3 cycles after the 4th sample, odata=4080 (0xFF0).
- **Signed** (macro defined): 4 samples, all lanes 0x80 → odata=-2048 (0x800). The same stimulus undefined → odata=2048.
- **Stall and bubbles:** samples with lanes {1,2,3,4}, interleaved with iVALID=0 cycles and 3-cycle iEN=0 windows → one result, odata=40. Strobe timing shifts by exactly the disabled cycles, and ovalid is never high twice.
- **Clear mid-group:** 2 samples of lanes 10, then iCLR plus a sample of 99, then 4 samples of lanes 1 → only one strobe, odata=16.
- **Back-to-back groups:** 8 continuous samples with all lanes equal to n, for n=1..8 → strobes 4 cycles apart, odata=40 then 104.
